// File: rtl/spi_slave_tx.sv
// SPI slave transmitter: a transmit FIFO feeds a shift register serialised on MISO in any SPI mode.
// Define SPI_SLAVE_TX_UNDERRUN_EN to enable the sticky underrun flag; when undefined it is tied low.
module spi_slave_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 1,
  parameter int CPHA       = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_WIDTH-1:0]       spi_tx_tData,
  input  logic                        spi_tx_tValid,
  output logic                        spi_tx_tReady,
  input  logic                        spi_cs,
  input  logic                        spi_clk,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        word_done,
  output logic                        abort,
  output logic                        underrun,
  input  logic                        underrun_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic SCK_IDLE = (CPOL != 0);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [2:0]            csSync_q, sckSync_q;
  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, src;
  logic                  miso_q, miso_d, first_q, first_d;
  logic                  wordDone_q, wordDone_d, abort_q, abort_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wrPtr_q, rdPtr_q;
  logic [AW:0]           level_q, level_d;
  logic                  rdy_q;
  logic                  csFall, csRise, sckLead, sckTrail;
  logic                  load, push, pop, fifoEmpty;
  logic [DATA_WIDTH-1:0] loadWord;

  function automatic logic firstBit(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b1} : {1'b1, w[DATA_WIDTH-1:1]};
  endfunction

  // Bit 2 of each synchroniser is the delayed copy used only for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csSync_q  <= 3'b111;
      sckSync_q <= {3{SCK_IDLE}};
    end else begin
      csSync_q  <= {csSync_q[1:0], spi_cs};
      sckSync_q <= {sckSync_q[1:0], spi_clk};
    end
  end

  assign csFall   = !csSync_q[1] && csSync_q[2];
  assign csRise   = csSync_q[1] && !csSync_q[2];
  assign sckLead  = (sckSync_q[1] != SCK_IDLE) && (sckSync_q[2] == SCK_IDLE);
  assign sckTrail = (sckSync_q[1] == SCK_IDLE) && (sckSync_q[2] != SCK_IDLE);

  assign fifoEmpty     = (level_q == '0);
  assign loadWord      = fifoEmpty ? '1 : mem_q[rdPtr_q];
  assign spi_tx_tReady = rdy_q && (level_q != FULL_LEVEL);
  assign push          = spi_tx_tValid && spi_tx_tReady;
  assign pop           = load && !fifoEmpty;

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shreg_d    = shreg_q;
    miso_d     = miso_q;
    first_d    = first_q;
    wordDone_d = 1'b0;
    abort_d    = 1'b0;
    load       = 1'b0;
    src        = shreg_q;
    if (state_q == ST_IDLE) begin
      miso_d = 1'b1;
      if (csFall) begin
        state_d  = ST_SHIFT;
        bitCnt_d = '0;
        load     = 1'b1;
        shreg_d  = loadWord;
        first_d  = 1'b1;
        if (CPHA == 0) miso_d = firstBit(loadWord);
      end
    end else begin
      // CS rise outranks a coincident trailing edge, so the word is never reported done.
      if (csRise) begin
        state_d  = ST_IDLE;
        miso_d   = 1'b1;
        bitCnt_d = '0;
        abort_d  = (bitCnt_q != '0);
      end else if (CPHA == 0) begin
        if (sckTrail) begin
          if (bitCnt_q == LAST_BIT) begin
            wordDone_d = 1'b1;
            bitCnt_d   = '0;
            load       = 1'b1;
            shreg_d    = loadWord;
            miso_d     = firstBit(loadWord);
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
            shreg_d  = advance(shreg_q);
            miso_d   = firstBit(advance(shreg_q));
          end
        end
      end else begin
        if (sckLead) begin
          if (bitCnt_q == '0 && !first_q) begin
            load = 1'b1;
            src  = loadWord;
          end
          first_d = 1'b0;
          miso_d  = firstBit(src);
          shreg_d = advance(src);
        end else if (sckTrail) begin
          if (bitCnt_q == LAST_BIT) begin
            wordDone_d = 1'b1;
            bitCnt_d   = '0;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      shreg_q    <= '1;
      miso_q     <= 1'b1;
      first_q    <= 1'b0;
      wordDone_q <= 1'b0;
      abort_q    <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shreg_q    <= shreg_d;
      miso_q     <= miso_d;
      first_q    <= first_d;
      wordDone_q <= wordDone_d;
      abort_q    <= abort_d;
      level_q    <= level_d;
      rdy_q      <= 1'b1;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= spi_tx_tData;
  end

`ifdef SPI_SLAVE_TX_UNDERRUN_EN
  logic underrun_q;
  always_ff @(posedge clk) begin
    if (!reset_n) underrun_q <= 1'b0;
    else if (load && fifoEmpty) underrun_q <= 1'b1;
    else if (underrun_clr) underrun_q <= 1'b0;
  end
  assign underrun = underrun_q;
`else
  logic unusedClr;
  assign unusedClr = underrun_clr;
  assign underrun  = 1'b0;
`endif

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == ST_SHIFT);
  assign busy        = (state_q == ST_SHIFT);
  assign word_done   = wordDone_q;
  assign abort       = abort_q;
  assign fifo_level  = level_q;
endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: a Mode 3 8-bit MSB-first DUT and a Mode 0 16-bit LSB-first DUT share CS and SCK timing.
// Expected streams come from a frame-level model: words loaded per frame, fill ones when the queue is dry.
module tb_spi_slave_tx;
  localparam int WA = 8;
  localparam int DA = 4;
  localparam int WB = 16;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cs = 1'b1;
  logic act = 1'b0;
  logic underrunClr = 1'b0;
  logic sckA, sckB;
  logic [WA-1:0] dataA = '0;
  logic [WB-1:0] dataB = '0;
  logic validA = 1'b0, validB = 1'b0;
  logic readyA, readyB, misoA, misoB, oeA, oeB, busyA, busyB;
  logic wdoneA, wdoneB, abortA, abortB, underA, underB;
  logic [$clog2(DA):0] levelA;
  logic [$clog2(DB):0] levelB;

  int total = 0;
  int bad = 0;
  int wdA = 0, wdB = 0, abA = 0, abB = 0;
  logic [31:0] qA[$];
  logic [31:0] qB[$];
  logic expUnA = 1'b0, expUnB = 1'b0;

  // SCK polarity differs per DUT, but leading/trailing edges coincide.
  assign sckA = ~act;
  assign sckB = act;

  always #5 clk = ~clk;

  spi_slave_tx #(.DATA_WIDTH(WA), .FIFO_DEPTH(DA), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) dutA (
    .clk(clk), .reset_n(reset_n), .spi_tx_tData(dataA), .spi_tx_tValid(validA),
    .spi_tx_tReady(readyA), .spi_cs(cs), .spi_clk(sckA), .spi_miso(misoA),
    .spi_miso_oe(oeA), .fifo_level(levelA), .busy(busyA), .word_done(wdoneA),
    .abort(abortA), .underrun(underA), .underrun_clr(underrunClr));

  spi_slave_tx #(.DATA_WIDTH(WB), .FIFO_DEPTH(DB), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) dutB (
    .clk(clk), .reset_n(reset_n), .spi_tx_tData(dataB), .spi_tx_tValid(validB),
    .spi_tx_tReady(readyB), .spi_cs(cs), .spi_clk(sckB), .spi_miso(misoB),
    .spi_miso_oe(oeB), .fifo_level(levelB), .busy(busyB), .word_done(wdoneB),
    .abort(abortB), .underrun(underB), .underrun_clr(underrunClr));

  always @(negedge clk) begin
    if (wdoneA) wdA++;
    if (wdoneB) wdB++;
    if (abortA) abA++;
    if (abortB) abB++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] modelStream(input logic [31:0] q[$], input int w, input bit msb, input int n);
    logic [63:0] s;
    logic [31:0] word;
    int k, b;
    s = '0;
    for (int j = 0; j < n; j++) begin
      k = j / w;
      b = j % w;
      word = (k < q.size()) ? q[k] : 32'hFFFF_FFFF;
      s[j] = msb ? word[w-1-b] : word[b];
    end
    return s;
  endfunction

  task automatic pushWord(input bit toB, input logic [31:0] w);
    @(negedge clk);
    if (!toB) begin
      dataA = w[WA-1:0];
      validA = 1'b1;
      checkOutput("readyA", readyA, qA.size() < DA);
      if (qA.size() < DA) qA.push_back({24'h0, w[WA-1:0]});
    end else begin
      dataB = w[WB-1:0];
      validB = 1'b1;
      checkOutput("readyB", readyB, qB.size() < DB);
      if (qB.size() < DB) qB.push_back({16'h0, w[WB-1:0]});
    end
    @(negedge clk);
    validA = 1'b0;
    validB = 1'b0;
    checkOutput("levelA", levelA, qA.size());
    checkOutput("levelB", levelB, qB.size());
  endtask

  task automatic clearUnderrun();
    @(negedge clk);
    underrunClr = 1'b1;
    @(negedge clk);
    underrunClr = 1'b0;
    @(negedge clk);
    expUnA = 1'b0;
    expUnB = 1'b0;
    checkOutput("underrunClrA", underA, expUnA);
    checkOutput("underrunClrB", underB, expUnB);
  endtask

  // One CS frame of n SCK cycles, each half period lasting 4 clk cycles.
  task automatic applyStimulus(input int n);
    int wdA0, wdB0, abA0, abB0, loadsA, loadsB;
    logic [63:0] capA, capB;
    capA = '0;
    capB = '0;
    wdA0 = wdA; wdB0 = wdB; abA0 = abA; abB0 = abB;
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        checkOutput("busyA", {busyA, oeA}, 2'b11);
        checkOutput("busyB", {busyB, oeB}, 2'b11);
      end
      capB[i] = misoB;
      act = 1'b1;
      repeat (4) @(negedge clk);
      capA[i] = misoA;
      act = 1'b0;
      repeat (4) @(negedge clk);
    end
    cs = 1'b1;
    repeat (4) @(negedge clk);
    loadsA = (n + WA - 1) / WA;
    if (loadsA < 1) loadsA = 1;
    loadsB = n / WB + 1;
    checkOutput("streamA", capA, modelStream(qA, WA, 1'b1, n));
    checkOutput("streamB", capB, modelStream(qB, WB, 1'b0, n));
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    if (loadsA > qA.size()) expUnA = 1'b1;
    if (loadsB > qB.size()) expUnB = 1'b1;
`endif
    repeat (loadsA) if (qA.size() > 0) void'(qA.pop_front());
    repeat (loadsB) if (qB.size() > 0) void'(qB.pop_front());
    checkOutput("wordDoneA", wdA - wdA0, n / WA);
    checkOutput("wordDoneB", wdB - wdB0, n / WB);
    checkOutput("abortA", abA - abA0, (n % WA) != 0);
    checkOutput("abortB", abB - abB0, (n % WB) != 0);
    checkOutput("idleA", {oeA, misoA, busyA}, 3'b010);
    checkOutput("idleB", {oeB, misoB, busyB}, 3'b010);
    checkOutput("frameLevelA", levelA, qA.size());
    checkOutput("frameLevelB", levelB, qB.size());
    checkOutput("underrunA", underA, expUnA);
    checkOutput("underrunB", underB, expUnB);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("resetA", {readyA, levelA, misoA, oeA, busyA, wdoneA, abortA, underA}, 10'b0_000_1_00000);
    checkOutput("resetB", {readyB, levelB, misoB, oeB, busyB, wdoneB, abortB, underB}, 11'b0_0000_1_00000);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", {readyA, readyB}, 2'b11);

    // 0xA5 on the Mode 3 DUT; the 16-bit DUT sees a partial word and aborts.
    pushWord(1'b0, 32'hA5);
    pushWord(1'b1, 32'h1234);
    applyStimulus(8);

    pushWord(1'b0, 32'h3C);
    pushWord(1'b0, 32'h81);
    pushWord(1'b1, 32'h1234);
    pushWord(1'b1, 32'hABCD);
    applyStimulus(16);

    // Fill the 4-deep FIFO; the fifth word is refused until a frame pops one.
    for (int i = 0; i < 5; i++) pushWord(1'b0, 32'h10 + i);
    applyStimulus(8);
    pushWord(1'b0, 32'h14);
    applyStimulus(32);

    // Empty FIFO sends the fill pattern.
    applyStimulus(8);
    clearUnderrun();

    // CS rises after 3 SCKs; the next frame carries the following word.
    pushWord(1'b0, 32'h55);
    pushWord(1'b0, 32'h66);
    applyStimulus(3);
    applyStimulus(8);

    for (int r = 0; r < 12; r++) begin
      int na, nb;
      na = $urandom_range(3, 0);
      nb = $urandom_range(3, 0);
      for (int i = 0; i < na; i++) pushWord(1'b0, $urandom);
      for (int i = 0; i < nb; i++) pushWord(1'b1, $urandom);
      applyStimulus($urandom_range(40, 0));
      if ($urandom_range(1, 0) == 1) clearUnderrun();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
